// File: rtl/regfile_write_buffer_pkg.sv
// regfile_write_buffer_pkg
// Shared constants for the register-file write buffer. The register file has
// 64-bit data and 32 entries, and index 31 is the zero register (XZR).
package regfile_write_buffer_pkg;
    localparam int DATA_W_DEF    = 64;
    localparam int ADDR_W_DEF    = 5;
    localparam int REGFILE_DEPTH = 32;
    localparam logic [4:0] XZR_IDX = 5'd31;
endpackage

// File: rtl/regfile_write_buffer_fifo.sv
// wb_fifo
// Circular buffer that holds pending register writes. Besides the usual
// head/tail/count, it presents every slot in age order (0 = oldest, at head)
// with a valid bit, so the forwarding search does not need pointer math.
//   clk, rst             clock, async active-high reset (clears pointers/count)
//   push, push_idx/data  enqueue at tail (caller guarantees !full)
//   pop                  dequeue head (caller guarantees !empty)
//   head_idx/head_data   oldest entry
//   count, full, empty   occupancy
//   age_idx/data/vld     age-ordered view of all slots
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              push_idx,
    input  logic [DATA_W-1:0]              push_data,
    output logic [ADDR_W-1:0]              head_idx,
    output logic [DATA_W-1:0]              head_data,
    output logic [CNT_W-1:0]               count,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH-1:0][ADDR_W-1:0]   age_idx,
    output logic [DEPTH-1:0][DATA_W-1:0]   age_data,
    output logic [DEPTH-1:0]               age_vld
);
    logic [DEPTH-1:0][ADDR_W-1:0] idx_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic [PTR_W-1:0]             head, tail;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_idx  = idx_mem[head];
    assign head_data = data_mem[head];

    // Storage is not reset: stale slots are masked by age_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[tail]  <= push_idx;
            data_mem[tail] <= push_data;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_idx[k]  = idx_mem[head + PTR_W'(k)];
            age_data[k] = data_mem[head + PTR_W'(k)];
            age_vld[k]  = (CNT_W'(k) < count);
        end
    end
endmodule

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
// Queues datapath results and drains them into the register-file write port
// at one per cycle, with youngest-match forwarding of pending writes.
//   Clk, Reset                 clock, async active-high reset
//   InValid/InReady/InRW/InData producer handshake (RW=31 is dropped)
//   Hold                       stall the drain for this cycle
//   RegWr/RW/BusW              registered register-file write port
//   QueryRA/RB, HitA/B, FwdA/B forwarding lookup
//   Count                      FIFO occupancy (output stage excluded)
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [ADDR_W-1:0] InRW,
    input  logic [DATA_W-1:0] InData,
    input  logic              Hold,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    input  logic [ADDR_W-1:0] QueryRA,
    input  logic [ADDR_W-1:0] QueryRB,
    output logic              HitA,
    output logic              HitB,
    output logic [DATA_W-1:0] FwdA,
    output logic [DATA_W-1:0] FwdB,
    output logic [CNT_W-1:0]  Count
);
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_IDX);

    logic                         push, pop, full, empty;
    logic [ADDR_W-1:0]            head_idx;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0][ADDR_W-1:0] age_idx;
    logic [DEPTH-1:0][DATA_W-1:0] age_data;
    logic [DEPTH-1:0]             age_vld;

    // InReady depends only on registered occupancy, so a pop in the same
    // cycle never reopens the input early.
    assign InReady = !full;
    assign push    = InValid && InReady && (InRW != XZR);
    assign pop     = !empty && !Hold;

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .push      (push),
        .pop       (pop),
        .push_idx  (InRW),
        .push_data (InData),
        .head_idx  (head_idx),
        .head_data (head_data),
        .count     (Count),
        .full      (full),
        .empty     (empty),
        .age_idx   (age_idx),
        .age_data  (age_data),
        .age_vld   (age_vld)
    );

    // Output stage: one-cycle write pulse; index/data hold when idle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWr <= 1'b0;
            RW    <= '0;
            BusW  <= '0;
        end else begin
            RegWr <= pop;
            if (pop) begin
                RW   <= head_idx;
                BusW <= head_data;
            end
        end
    end

    // Oldest candidate first (output stage, then head..tail-1) so each later
    // match overrides, leaving the youngest one.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] q);
        logic [DATA_W:0] r;
        r = '0;
        if (RegWr && RW == q) r = {1'b1, BusW};
        for (int k = 0; k < DEPTH; k++)
            if (age_vld[k] && age_idx[k] == q) r = {1'b1, age_data[k]};
        if (q == XZR) r = '0;
        return r;
    endfunction

    always_comb begin
        {HitA, FwdA} = lookup(QueryRA);
        {HitB, FwdB} = lookup(QueryRB);
    end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed scenarios followed by a random
// stream, every cycle checked against a queue-based reference model.
module tb_regfile_write_buffer;
    localparam int DEPTH = 4;

    logic        Clk, Reset, InValid, InReady, Hold, RegWr, HitA, HitB;
    logic [4:0]  InRW, RW, QueryRA, QueryRB;
    logic [63:0] InData, BusW, FwdA, FwdB;
    logic [2:0]  Count;

    regfile_write_buffer #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InRW(InRW), .InData(InData), .Hold(Hold), .RegWr(RegWr), .RW(RW),
        .BusW(BusW), .QueryRA(QueryRA), .QueryRB(QueryRB), .HitA(HitA),
        .HitB(HitB), .FwdA(FwdA), .FwdB(FwdB), .Count(Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed { logic [4:0] idx; logic [63:0] data; } ent_t;
    ent_t        q[$];        // pending writes, oldest first
    ent_t        acc[$];      // accepted (stored) writes
    ent_t        wrs[$];      // writes seen on the register-file port
    logic        m_wr;
    logic [4:0]  m_rw;
    logic [63:0] m_bus;
    int checks, failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest pending value for an index, else the in-flight write.
    function automatic void model_fwd(input logic [4:0] qi, output logic h, output logic [63:0] f);
        h = 1'b0; f = '0;
        if (qi == 5'd31) return;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].idx == qi) begin h = 1'b1; f = q[i].data; return; end
        if (m_wr && m_rw == qi) begin h = 1'b1; f = m_bus; end
    endfunction

    // Entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [4:0] idx, input logic [63:0] d,
                         input logic h, input logic [4:0] qa, input logic [4:0] qb);
        logic acc_ok, do_pop, eh;
        logic [63:0] ef;
        InValid = v; InRW = idx; InData = d; Hold = h; QueryRA = qa; QueryRB = qb;
        #1;
        chk("in_ready", InReady, q.size() != DEPTH);
        chk("count_pre", Count, q.size());
        model_fwd(qa, eh, ef); chk("hit_a", HitA, eh); chk("fwd_a", FwdA, ef);
        model_fwd(qb, eh, ef); chk("hit_b", HitB, eh); chk("fwd_b", FwdB, ef);
        acc_ok = v && (q.size() != DEPTH);
        do_pop = (q.size() > 0) && !h;
        @(posedge Clk);
        if (do_pop) begin
            m_wr = 1'b1; m_rw = q[0].idx; m_bus = q[0].data;
            void'(q.pop_front());
        end else m_wr = 1'b0;
        if (acc_ok && idx != 5'd31) begin
            q.push_back('{idx, d});
            acc.push_back('{idx, d});
        end
        #1;
        chk("reg_wr", RegWr, m_wr);
        chk("rw", RW, m_rw);
        chk("bus_w", BusW, m_bus);
        chk("count", Count, q.size());
        if (RegWr) wrs.push_back('{RW, BusW});
    endtask

    initial begin
        checks = 0; failures = 0;
        Reset = 1'b1; InValid = 0; InRW = 0; InData = 0; Hold = 0; QueryRA = 0; QueryRB = 0;
        m_wr = 0; m_rw = 0; m_bus = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_regwr", RegWr, 0); chk("rst_count", Count, 0); chk("rst_inready", InReady, 1);
        Reset = 1'b0;

        // Single write
        cycle(1, 5'd5, 64'hDEAD_BEEF, 0, 5'd5, 5'd0);
        cycle(0, 5'd0, 0, 0, 5'd5, 5'd0);
        chk("single_regwr", RegWr, 1); chk("single_rw", RW, 5); chk("single_busw", BusW, 64'hDEAD_BEEF);
        cycle(0, 5'd0, 0, 0, 5'd5, 5'd0);
        chk("single_drop", RegWr, 0);

        // Full / backpressure
        for (int i = 0; i < 4; i++) cycle(1, 5'(i + 1), 64'(100 + i), 1, 5'd1, 5'd4);
        #1; chk("full_inready", InReady, 0); chk("full_count", Count, 4);
        cycle(1, 5'd9, 64'd999, 1, 5'd9, 5'd2);        // not taken
        cycle(1, 5'd9, 64'd998, 0, 5'd9, 5'd2);        // pop; still not taken
        chk("first_pop_rw", RW, 1);
        cycle(1, 5'd10, 64'd555, 0, 5'd10, 5'd3);      // InReady back
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 5'd10, 5'd4);

        // XZR filter
        cycle(1, 5'd31, 64'd7, 0, 5'd31, 5'd31);
        chk("xzr_count", Count, 0);
        cycle(0, 0, 0, 0, 5'd31, 5'd31);
        chk("xzr_regwr", RegWr, 0); chk("xzr_hit", HitA, 0); chk("xzr_fwd", FwdA, 0);

        // Forwarding
        cycle(1, 5'd3, 64'd10, 1, 5'd3, 5'd4);
        cycle(1, 5'd3, 64'd20, 1, 5'd3, 5'd4);
        cycle(1, 5'd4, 64'd30, 1, 5'd3, 5'd4);
        InValid = 0; QueryRA = 5'd3; QueryRB = 5'd4; #1;
        chk("fwd_hit_a", HitA, 1); chk("fwd_a_young", FwdA, 20); chk("fwd_b", FwdB, 30);
        QueryRA = 5'd9; #1;
        chk("fwd_miss", HitA, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 5'd3, 5'd4);
        chk("drained_hit_a", HitA, 0); chk("drained_hit_b", HitB, 0);

        // Reset mid-drain with 3 queued and a write in flight
        for (int i = 0; i < 4; i++) cycle(1, 5'(i + 20), 64'(700 + i), 1, 5'd20, 5'd21);
        cycle(0, 0, 0, 0, 5'd21, 5'd22);
        #2 Reset = 1'b1; #1;
        chk("mid_rst_regwr", RegWr, 0); chk("mid_rst_rw", RW, 0); chk("mid_rst_busw", BusW, 0);
        chk("mid_rst_count", Count, 0); chk("mid_rst_inready", InReady, 1);
        chk("mid_rst_hit", HitA, 0); chk("mid_rst_fwd", FwdA, 0);
        q.delete(); m_wr = 0; m_rw = 0; m_bus = 0;
        @(posedge Clk); #1; Reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 5'd22, 5'd23);

        // Random stream with wrap-around
        acc.delete(); wrs.delete();
        for (int n = 0; n < 300 && acc.size() < 12; n++) begin
            logic [4:0] ri;
            ri = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            cycle($urandom_range(0, 3) != 0, ri, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7)));
        end
        for (int n = 0; n < 50 && (q.size() > 0 || m_wr); n++)
            cycle(0, 0, 0, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        chk("stream_len", wrs.size(), acc.size());
        chk("stream_min_len", acc.size() >= 10, 1);
        for (int i = 0; i < acc.size() && i < wrs.size(); i++)
            chk("stream_order", wrs[i], acc[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
